// File: rtl/keypad_time_loader_if.sv
// Keypad-side bundle for keypad_time_loader: key/control inputs in,
// BCD load data and status out.
interface keypad_time_loader_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       start;
    logic       clear_key;
    logic       timer_done;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       loadn;
    logic [2:0] digit_count;
    logic       locked;
    logic       err;

    modport master (
        output key_valid, key_code, start, clear_key, timer_done,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  loadn, digit_count, locked, err
    );

    modport slave (
        input  key_valid, key_code, start, clear_key, timer_done,
        output min_tens, min_ones, sec_tens, sec_ones,
        output loadn, digit_count, locked, err
    );
endinterface

// File: rtl/keypad_time_loader.sv
// Shifts keypad digits into an MM:SS BCD entry, validates it on start and
// issues a one-cycle active-low parallel load into the timer digit counters.
module keypad_time_loader #(
    parameter int unsigned SEC_TENS_MAX = 5,
    parameter int unsigned MIN_TENS_MAX = 9
) (
    input  logic                  clk,
    input  logic                  clrn,
    keypad_time_loader_if.slave   bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ENTRY  = 2'd1;
    localparam logic [1:0] ST_LOAD   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam logic [3:0] LP_SEC_TENS_MAX = 4'(SEC_TENS_MAX);
    localparam logic [3:0] LP_MIN_TENS_MAX = 4'(MIN_TENS_MAX);

    logic [1:0] r_state;
    logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
    logic [2:0] r_count;
    logic       r_loadn;
    logic       r_locked;
    logic       r_err;

    logic [1:0] w_n_state;
    logic [3:0] w_n_min_tens, w_n_min_ones, w_n_sec_tens, w_n_sec_ones;
    logic [2:0] w_n_count;
    logic       w_n_loadn;
    logic       w_n_err;
    logic       w_digit_key;
    logic       w_bad_entry;
    logic       w_zero_entry;

    assign w_digit_key  = bus.key_valid && (bus.key_code <= 4'd9);
    assign w_bad_entry  = (r_sec_tens > LP_SEC_TENS_MAX) || (r_min_tens > LP_MIN_TENS_MAX);
    assign w_zero_entry = ({r_min_tens, r_min_ones, r_sec_tens, r_sec_ones} == 16'h0000);

    // Priority clear > start > key; a key coinciding with start is dropped.
    always_comb begin
        w_n_state    = r_state;
        w_n_min_tens = r_min_tens;
        w_n_min_ones = r_min_ones;
        w_n_sec_tens = r_sec_tens;
        w_n_sec_ones = r_sec_ones;
        w_n_count    = r_count;
        w_n_loadn    = 1'b1;
        w_n_err      = r_err;
        if (bus.clear_key) begin
            w_n_state    = ST_IDLE;
            w_n_min_tens = '0;
            w_n_min_ones = '0;
            w_n_sec_tens = '0;
            w_n_sec_ones = '0;
            w_n_count    = '0;
            w_n_err      = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ENTRY: begin
                    if (bus.start) begin
                        if (r_state == ST_ENTRY) begin
                            if (w_bad_entry) begin
                                w_n_err = 1'b1;
                            end else if (!w_zero_entry) begin
                                w_n_state = ST_LOAD;
                                w_n_loadn = 1'b0;
                            end
                        end
                    end else if (w_digit_key && (r_count != 3'd4)) begin
                        w_n_min_tens = r_min_ones;
                        w_n_min_ones = r_sec_tens;
                        w_n_sec_tens = r_sec_ones;
                        w_n_sec_ones = bus.key_code;
                        w_n_count    = r_count + 3'd1;
                        w_n_err      = 1'b0;
                        w_n_state    = ST_ENTRY;
                    end
                end
                ST_LOAD: begin
                    w_n_state = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (bus.timer_done) begin
                        w_n_state    = ST_IDLE;
                        w_n_min_tens = '0;
                        w_n_min_ones = '0;
                        w_n_sec_tens = '0;
                        w_n_sec_ones = '0;
                        w_n_count    = '0;
                    end
                end
                default: begin
                    w_n_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state    <= ST_IDLE;
            r_min_tens <= '0;
            r_min_ones <= '0;
            r_sec_tens <= '0;
            r_sec_ones <= '0;
            r_count    <= '0;
            r_loadn    <= 1'b1;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_n_state;
            r_min_tens <= w_n_min_tens;
            r_min_ones <= w_n_min_ones;
            r_sec_tens <= w_n_sec_tens;
            r_sec_ones <= w_n_sec_ones;
            r_count    <= w_n_count;
            r_loadn    <= w_n_loadn;
            r_locked   <= (w_n_state == ST_LOAD) || (w_n_state == ST_LOCKED);
            r_err      <= w_n_err;
        end
    end

    assign bus.min_tens    = r_min_tens;
    assign bus.min_ones    = r_min_ones;
    assign bus.sec_tens    = r_sec_tens;
    assign bus.sec_ones    = r_sec_ones;
    assign bus.digit_count = r_count;
    assign bus.loadn       = r_loadn;
    assign bus.locked      = r_locked;
    assign bus.err         = r_err;

endmodule

// File: tb/tb_keypad_time_loader.sv
// Directed bench for keypad_time_loader: digit entry, validation, load
// strobe timing, lockout, clear priority and asynchronous reset.
module tb_keypad_time_loader;

    logic clk = 1'b0;
    logic clrn;
    int   n_assert = 0;
    int   n_fail   = 0;

    keypad_time_loader_if kif ();

    keypad_time_loader #(
        .SEC_TENS_MAX(5),
        .MIN_TENS_MAX(9)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (kif)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] code);
        kif.key_valid = 1'b1;
        kif.key_code  = code;
        tick();
        kif.key_valid = 1'b0;
        kif.key_code  = 4'd0;
    endtask

    task automatic pulse_start;
        kif.start = 1'b1;
        tick();
        kif.start = 1'b0;
    endtask

    task automatic pulse_done;
        kif.timer_done = 1'b1;
        tick();
        kif.timer_done = 1'b0;
    endtask

    task automatic pulse_clear;
        kif.clear_key = 1'b1;
        tick();
        kif.clear_key = 1'b0;
    endtask

    function automatic logic [15:0] digits();
        return {kif.min_tens, kif.min_ones, kif.sec_tens, kif.sec_ones};
    endfunction

    initial begin
        clrn           = 1'b0;
        kif.key_valid  = 1'b0;
        kif.key_code   = 4'd0;
        kif.start      = 1'b0;
        kif.clear_key  = 1'b0;
        kif.timer_done = 1'b0;
        #12;
        chk("rst_digits", digits(), 16'h0000);
        chk("rst_loadn", 16'(kif.loadn), 16'h1);
        chk("rst_count", 16'(kif.digit_count), 16'h0);
        chk("rst_locked", 16'(kif.locked), 16'h0);
        chk("rst_err", 16'(kif.err), 16'h0);
        clrn = 1'b1;
        tick();

        // 1,3,0 -> 01:30
        key(4'd1);
        chk("k1_digits", digits(), 16'h0001);
        key(4'd3);
        key(4'd0);
        chk("k130_digits", digits(), 16'h0130);
        chk("k130_count", 16'(kif.digit_count), 16'h3);
        chk("k130_loadn", 16'(kif.loadn), 16'h1);
        chk("k130_locked", 16'(kif.locked), 16'h0);

        pulse_start();
        chk("ld_loadn_low", 16'(kif.loadn), 16'h0);
        chk("ld_digits", digits(), 16'h0130);
        chk("ld_locked", 16'(kif.locked), 16'h1);
        tick();
        chk("ld_loadn_high", 16'(kif.loadn), 16'h1);
        chk("ld_digits_hold", digits(), 16'h0130);
        chk("lk_locked", 16'(kif.locked), 16'h1);
        key(4'd7);
        chk("lk_key_digits", digits(), 16'h0130);
        chk("lk_key_count", 16'(kif.digit_count), 16'h3);
        pulse_start();
        chk("lk_start_loadn", 16'(kif.loadn), 16'h1);
        pulse_done();
        chk("done_digits", digits(), 16'h0000);
        chk("done_count", 16'(kif.digit_count), 16'h0);
        chk("done_locked", 16'(kif.locked), 16'h0);

        // start in IDLE is ignored
        pulse_start();
        chk("idle_start_loadn", 16'(kif.loadn), 16'h1);
        chk("idle_start_locked", 16'(kif.locked), 16'h0);

        // 9,9,9,9,5 -> fifth key dropped, invalid seconds tens
        key(4'd9);
        key(4'd9);
        key(4'd9);
        key(4'd9);
        key(4'd5);
        chk("k9999_digits", digits(), 16'h9999);
        chk("k9999_count", 16'(kif.digit_count), 16'h4);
        pulse_start();
        chk("bad_err", 16'(kif.err), 16'h1);
        chk("bad_loadn", 16'(kif.loadn), 16'h1);
        chk("bad_locked", 16'(kif.locked), 16'h0);
        tick();
        chk("bad_loadn2", 16'(kif.loadn), 16'h1);
        pulse_clear();
        chk("clr_err", 16'(kif.err), 16'h0);
        chk("clr_digits", digits(), 16'h0000);
        chk("clr_count", 16'(kif.digit_count), 16'h0);

        // all-zero entry: start ignored, then 00:05 loads
        key(4'd0);
        chk("k0_count", 16'(kif.digit_count), 16'h1);
        pulse_start();
        chk("zero_loadn", 16'(kif.loadn), 16'h1);
        chk("zero_err", 16'(kif.err), 16'h0);
        chk("zero_locked", 16'(kif.locked), 16'h0);
        key(4'd5);
        chk("k05_digits", digits(), 16'h0005);
        chk("k05_count", 16'(kif.digit_count), 16'h2);
        pulse_start();
        chk("ld05_loadn", 16'(kif.loadn), 16'h0);
        chk("ld05_digits", digits(), 16'h0005);
        tick();
        chk("ld05_loadn_high", 16'(kif.loadn), 16'h1);
        pulse_done();
        chk("done05_locked", 16'(kif.locked), 16'h0);

        // start with a coincident key: key dropped
        key(4'd1);
        key(4'd2);
        kif.key_valid = 1'b1;
        kif.key_code  = 4'd4;
        pulse_start();
        kif.key_valid = 1'b0;
        chk("sk_loadn", 16'(kif.loadn), 16'h0);
        chk("sk_digits", digits(), 16'h0012);
        chk("sk_count", 16'(kif.digit_count), 16'h2);
        tick();
        pulse_done();

        // timer_done outside LOCKED ignored; clear beats start
        key(4'd4);
        pulse_done();
        chk("entry_done_digits", digits(), 16'h0004);
        chk("entry_done_count", 16'(kif.digit_count), 16'h1);
        kif.clear_key = 1'b1;
        pulse_start();
        kif.clear_key = 1'b0;
        chk("cs_loadn", 16'(kif.loadn), 16'h1);
        chk("cs_locked", 16'(kif.locked), 16'h0);
        chk("cs_digits", digits(), 16'h0000);
        tick();
        chk("cs_loadn2", 16'(kif.loadn), 16'h1);

        // seconds-tens 6 rejected, later key clears err, 16:05 loads
        key(4'd1);
        key(4'd6);
        key(4'd0);
        pulse_start();
        chk("s6_err", 16'(kif.err), 16'h1);
        chk("s6_loadn", 16'(kif.loadn), 16'h1);
        key(4'd5);
        chk("s6_key_err", 16'(kif.err), 16'h0);
        chk("s6_key_digits", digits(), 16'h1605);
        pulse_start();
        chk("ld1605_loadn", 16'(kif.loadn), 16'h0);
        tick();
        pulse_clear();
        chk("lk_clear_locked", 16'(kif.locked), 16'h0);
        chk("lk_clear_digits", digits(), 16'h0000);

        // seconds-tens 5 is the legal boundary
        key(4'd5);
        key(4'd9);
        pulse_start();
        chk("s5_loadn", 16'(kif.loadn), 16'h0);
        chk("s5_err", 16'(kif.err), 16'h0);
        tick();
        pulse_done();

        // asynchronous reset during the load cycle
        key(4'd2);
        pulse_start();
        chk("rl_loadn_low", 16'(kif.loadn), 16'h0);
        #2;
        clrn = 1'b0;
        #1;
        chk("rl_loadn", 16'(kif.loadn), 16'h1);
        chk("rl_digits", digits(), 16'h0000);
        chk("rl_locked", 16'(kif.locked), 16'h0);
        chk("rl_count", 16'(kif.digit_count), 16'h0);
        #2;
        clrn = 1'b1;
        tick();
        for (int c = 10; c <= 15; c++) begin
            key(4'(c));
        end
        chk("nd_digits", digits(), 16'h0000);
        chk("nd_count", 16'(kif.digit_count), 16'h0);
        key(4'd8);
        chk("post_rst_digits", digits(), 16'h0008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
